// File: rtl/pic_bus_if.sv
// pic_bus_if
//   Groups the host command/response, init sequencer and 8259 bus signals
//   of pic_bus_master.
//   master modport: the bus initiator (pic_bus_master) view.
//   slave  modport: the host / PIC-side environment view.
//
// Host handshake: a command transfers on a rising clk edge where cmd_valid
// and cmd_ready are both 1. cmd_write/cmd_a0/cmd_data must be stable while
// cmd_valid is 1. cmd_ready may depend on init_start in the same cycle.
// rsp_valid is a one-cycle pulse with no back-pressure.
interface pic_bus_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic       cmd_a0;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       init_start;
  logic [7:0] icw1;
  logic [7:0] icw2;
  logic [7:0] icw3;
  logic [7:0] icw4;
  logic       init_busy;
  logic       init_done;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  modport master (
    input  cmd_valid, cmd_write, cmd_a0, cmd_data,
    input  init_start, icw1, icw2, icw3, icw4, data_in,
    output cmd_ready, rsp_valid, rsp_data, init_busy, init_done,
    output cs_n, rd_n, wr_n, A0, data_out, data_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_a0, cmd_data,
    output init_start, icw1, icw2, icw3, icw4, data_in,
    input  cmd_ready, rsp_valid, rsp_data, init_busy, init_done,
    input  cs_n, rd_n, wr_n, A0, data_out, data_oe
  );
endinterface

// File: rtl/pic_bus_master.sv
// pic_bus_master
//   CPU-side 8080-style bus initiator for an 8259 PIC. Turns single-cycle
//   host commands into timed bus cycles (setup / strobe / hold / recover)
//   and runs an automatic ICW1..ICW4 init sequence.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   bus         pic_bus_if.master: host command/response, init control,
//               PIC bus strobes, A0 and data
//   o_dbg_state current bus FSM state (debug)
module pic_bus_master #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  pic_bus_if.master  bus,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // Counters hold "cycles remaining minus one" so zero marks the last cycle.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_lat_write, w_write_nxt;
  logic       r_lat_a0, w_a0_nxt;
  logic [7:0] r_lat_data, w_data_nxt;

  logic       r_init_busy, r_init_done;
  logic [1:0] r_step, w_step_nxt;
  logic       w_has_next;
  logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4, w_icw_sel;

  logic       r_cs_n, r_rd_n, r_wr_n, r_a0, r_data_oe, r_rsp_valid;
  logic [7:0] r_data_out, r_rsp_data;

  logic       w_ready, w_init_go, w_cmd_go, w_icw_go, w_cnt_zero, w_bus_on;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_cnt_zero  = (r_cnt == 8'd0);
    // init_start wins over a simultaneous host command.
    w_ready     = (r_state == ST_IDLE) && !r_init_busy && !bus.init_start && !reset;
    w_init_go   = (r_state == ST_IDLE) && !r_init_busy && bus.init_start;
    w_cmd_go    = w_ready && bus.cmd_valid;
    w_icw_go    = (r_state == ST_IDLE) && r_init_busy;

    case (r_step)
      2'd0:    w_icw_sel = r_icw1;
      2'd1:    w_icw_sel = r_icw2;
      2'd2:    w_icw_sel = r_icw3;
      default: w_icw_sel = r_icw4;
    endcase

    // ICW3 only in cascade mode (icw1[1]=0), ICW4 only when icw1[0]=1.
    w_has_next = 1'b0;
    w_step_nxt = r_step;
    case (r_step)
      2'd0: begin w_has_next = 1'b1; w_step_nxt = 2'd1; end
      2'd1: begin
        if (!r_icw1[1])    begin w_has_next = 1'b1; w_step_nxt = 2'd2; end
        else if (r_icw1[0]) begin w_has_next = 1'b1; w_step_nxt = 2'd3; end
      end
      2'd2: if (r_icw1[0]) begin w_has_next = 1'b1; w_step_nxt = 2'd3; end
      default: w_has_next = 1'b0;
    endcase

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_write_nxt = r_lat_write;
    w_a0_nxt    = r_lat_a0;
    w_data_nxt  = r_lat_data;
    case (r_state)
      ST_IDLE: begin
        if (w_icw_go) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = SETUP_LD;
          w_write_nxt = 1'b1;
          w_a0_nxt    = (r_step != 2'd0);
          w_data_nxt  = w_icw_sel;
        end else if (w_cmd_go) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = SETUP_LD;
          w_write_nxt = bus.cmd_write;
          w_a0_nxt    = bus.cmd_a0;
          w_data_nxt  = bus.cmd_data;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin w_state_nxt = ST_STROBE; w_cnt_nxt = STROBE_LD; end
        else w_cnt_nxt = r_cnt - 8'd1;
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin w_state_nxt = ST_HOLD; w_cnt_nxt = HOLD_LD; end
        else w_cnt_nxt = r_cnt - 8'd1;
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin w_state_nxt = ST_RECOVER; w_cnt_nxt = RECOVER_LD; end
        else w_cnt_nxt = r_cnt - 8'd1;
      end
      ST_RECOVER: begin
        if (w_cnt_zero) begin w_state_nxt = ST_IDLE; w_cnt_nxt = 8'd0; end
        else w_cnt_nxt = r_cnt - 8'd1;
      end
      default: begin w_state_nxt = ST_IDLE; w_cnt_nxt = 8'd0; end
    endcase

    w_bus_on = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
               (w_state_nxt == ST_HOLD);
  end

  // Bus outputs are registered from the next state so they line up exactly
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 8'd0;
      r_lat_write <= 1'b0;
      r_lat_a0    <= 1'b0;
      r_lat_data  <= 8'd0;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_a0        <= 1'b0;
      r_data_out  <= 8'd0;
      r_data_oe   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_init_busy <= 1'b0;
      r_init_done <= 1'b0;
      r_step      <= 2'd0;
      r_icw1      <= 8'd0;
      r_icw2      <= 8'd0;
      r_icw3      <= 8'd0;
      r_icw4      <= 8'd0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_lat_write <= w_write_nxt;
      r_lat_a0    <= w_a0_nxt;
      r_lat_data  <= w_data_nxt;
      r_cs_n      <= !w_bus_on;
      r_wr_n      <= !((w_state_nxt == ST_STROBE) && w_write_nxt);
      r_rd_n      <= !((w_state_nxt == ST_STROBE) && !w_write_nxt);
      r_a0        <= w_a0_nxt;
      r_data_out  <= w_data_nxt;
      r_data_oe   <= w_bus_on && w_write_nxt;

      // Read data is taken on the edge ending the last strobe cycle; the
      // pulse then lands in the first hold cycle.
      r_rsp_valid <= (r_state == ST_STROBE) && w_cnt_zero && !r_lat_write;
      if ((r_state == ST_STROBE) && w_cnt_zero && !r_lat_write)
        r_rsp_data <= bus.data_in;

      r_init_done <= 1'b0;
      if (w_init_go) begin
        r_icw1      <= bus.icw1;
        r_icw2      <= bus.icw2;
        r_icw3      <= bus.icw3;
        r_icw4      <= bus.icw4;
        r_init_busy <= 1'b1;
        r_step      <= 2'd0;
      end else if (r_init_busy && (r_state == ST_RECOVER) && w_cnt_zero) begin
        if (w_has_next) begin
          r_step <= w_step_nxt;
        end else begin
          r_init_busy <= 1'b0;
          r_init_done <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.init_busy = r_init_busy;
  assign bus.init_done = r_init_done;
  assign bus.cs_n      = r_cs_n;
  assign bus.rd_n      = r_rd_n;
  assign bus.wr_n      = r_wr_n;
  assign bus.A0        = r_a0;
  assign bus.data_out  = r_data_out;
  assign bus.data_oe   = r_data_oe;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/pic_bus_master.md
Name: pic_bus_master

Overview:
- CPU-side bus initiator for the 8259 PIC register interface; drives cs_n, rd_n, wr_n, A0 and the 8-bit data bus toward the PIC's bus control logic.
- Converts single-cycle host commands (write or read, A0, data) into timed 8080-style bus cycles with programmable setup, strobe, hold and recovery.
- Contains an init sequencer that issues ICW1, ICW2, ICW3 (optional) and ICW4 (optional) automatically.
- Sits between the testbench/CPU model and the PIC top level.

Parameters:
- SETUP_CYC, 1, cycles with cs_n low and A0/data valid before the strobe falls (min 1)
- STROBE_CYC, 2, cycles rd_n or wr_n is held low (min 1)
- HOLD_CYC, 1, cycles after the strobe rises with cs_n, A0 and data held (min 1)
- RECOVER_CYC, 1, cycles with cs_n high before the next cycle may start (min 1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command request
- cmd_ready  out  1  block can accept a command this cycle
- cmd_write  in  1  1 = write cycle, 0 = read cycle
- cmd_a0  in  1  A0 value for the cycle
- cmd_data  in  8  write data
- rsp_valid  out  1  one-cycle pulse when read data is available
- rsp_data  out  8  last read data, held until the next read
- init_start  in  1  starts the ICW sequence
- icw1, icw2, icw3, icw4  in  8 each  init words, captured at init_start
- init_busy  out  1  ICW sequence in progress
- init_done  out  1  one-cycle pulse when the sequence completes
- cs_n, rd_n, wr_n  out  1 each  PIC bus strobes, active low
- A0  out  1  PIC address line
- data_out  out  8  bus write data
- data_oe  out  1  1 = drive data_out onto the bus (top level builds the tristate)
- data_in  in  8  bus read data

Behaviour:
- All bus outputs are registered. Reset values: cs_n=rd_n=wr_n=1, A0=0, data_out=0, data_oe=0, rsp_valid=0, rsp_data=0, init_busy=0, init_done=0. cmd_ready=0 while reset is high.
- Bus FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. Each non-IDLE state uses an 8-bit down-counter loaded with its parameter value.
- IDLE:
  - cmd_ready = 1 when not init_busy.
  - A command is accepted when cmd_valid & cmd_ready; A0, write flag and data are latched.
  - The next cycle enters SETUP.
- SETUP: cs_n=0, A0 valid. For a write, data_oe=1 and data_out=data. For a read, data_oe=0.
- STROBE: wr_n=0 for a write, rd_n=0 for a read. cs_n, A0 and data stay stable.
  - Reads sample data_in into rsp_data on the clock edge that ends the last STROBE cycle.
- HOLD: strobes are back to 1. cs_n=0, A0 and data_oe are unchanged.
  - rsp_valid=1 in the first HOLD cycle of a read only.
- RECOVER: cs_n=1, data_oe=0. Then return to IDLE.
- Cycle length is SETUP_CYC+STROBE_CYC+HOLD_CYC+RECOVER_CYC (5 with defaults) plus 1 IDLE cycle between back-to-back commands.
- wr_n and rd_n are never low together. A strobe is never low while cs_n=1.
- Init sequencer:
  - init_start in IDLE captures icw1–icw4 and sets init_busy the next cycle.
  - Issues ICW1 with A0=0, then ICW2 with A0=1.
  - Issues ICW3 with A0=1 only if icw1[1]=0 (cascade mode).
  - Issues ICW4 with A0=1 only if icw1[0]=1.
  - ICW cycles use the same bus FSM timing.
  - After the final RECOVER: init_done pulses for 1 cycle and init_busy clears in the same cycle.
  - Host commands are blocked (cmd_ready=0) throughout.
- Simultaneous events and ignored inputs:
  - init_start and cmd_valid in the same IDLE cycle: init wins, the command is not accepted, cmd_ready=0.
  - init_start while busy is ignored.
- Reset mid-cycle: on the next edge all outputs return to reset values, the FSM returns to IDLE, and the init sequence aborts with no init_done pulse.

Test Plan:
- Write A0=1, data=0xA5, default params: cs_n low for 4 cycles, wr_n low 2 cycles in cycles 2–3 of the cs_n window, data_oe=1 with data_out=0xA5 throughout cs_n low; rd_n stays 1.
- Read A0=0, data_in=0x5A held: rd_n low 2 cycles; rsp_valid pulses once in the first HOLD cycle with rsp_data=0x5A; data_oe stays 0.
- init_start with icw1=0x13, icw2=0x20, icw4=0x01: exactly 3 writes (0x13/A0=0, 0x20/A0=1, 0x01/A0=1); init_done single pulse; cmd_ready=0 throughout.
- init_start with icw1=0x11, icw3=0x04: exactly 4 writes, with ICW3=0x04 issued third; icw1=0x12 gives 2 writes only.
- init_start and cmd_valid in the same cycle: init sequence runs; the command is accepted only after init_done, producing its cycle afterwards.
- Reset asserted during STROBE of a write: next edge cs_n=wr_n=1, data_oe=0; no rsp_valid or init_done; cmd_ready=1 the cycle after reset deasserts.
